// File: rtl/ns_responder.sv
// Responder for the Lowe-fixed Needham-Schroeder exchange: answers step 1 with step 2,
// tracks up to NUM_SLOTS sessions, commits on a matching step 3 and aborts on timeout.
module ns_responder #(
  parameter int unsigned AW         = 3,
  parameter int unsigned SELF       = 1,
  parameter int unsigned NUM_SLOTS  = 2,
  parameter int unsigned NONCE_BASE = 4,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_type,
  input  logic [AW-1:0]          in_src,
  input  logic [AW-1:0]          in_dest,
  input  logic [AW-1:0]          in_key,
  input  logic [AW-1:0]          in_nonce1,
  input  logic [AW-1:0]          in_nonce2,
  input  logic [AW-1:0]          in_address,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_type,
  output logic [AW-1:0]          out_src,
  output logic [AW-1:0]          out_dest,
  output logic [AW-1:0]          out_key,
  output logic [AW-1:0]          out_nonce1,
  output logic [AW-1:0]          out_nonce2,
  output logic [AW-1:0]          out_address,
  input  logic                   release_valid,
  input  logic [1:0]             release_slot,
  output logic                   commit,
  output logic [1:0]             commit_slot,
  output logic [AW-1:0]          commit_partner,
  output logic                   abort,
  output logic [1:0]             abort_slot,
  output logic                   drop,
  output logic [2*NUM_SLOTS-1:0] slot_state
);

  localparam int unsigned CW = 8;
  localparam int unsigned IW = 2;
  localparam logic [AW-1:0] SELF_ID = AW'(SELF);
  localparam logic [1:0] T_NA  = 2'd1;
  localparam logic [1:0] T_NNA = 2'd2;
  localparam logic [1:0] T_N   = 2'd3;

  typedef enum logic [1:0] {
    SLEEPING  = 2'd0,
    WAITING   = 2'd1,
    COMMITTED = 2'd2
  } slot_e;

  typedef struct packed {
    logic [1:0]    mtype;
    logic [AW-1:0] src;
    logic [AW-1:0] dest;
    logic [AW-1:0] key;
    logic [AW-1:0] nonce1;
    logic [AW-1:0] nonce2;
    logic [AW-1:0] address;
  } msg_t;

  slot_e         st_q      [NUM_SLOTS];
  slot_e         st_d      [NUM_SLOTS];
  logic [AW-1:0] partner_q [NUM_SLOTS];
  logic [AW-1:0] partner_d [NUM_SLOTS];
  logic [AW-1:0] na_q      [NUM_SLOTS];
  logic [AW-1:0] na_d      [NUM_SLOTS];
  logic [CW-1:0] cnt_q     [NUM_SLOTS];
  logic [CW-1:0] cnt_d     [NUM_SLOTS];

  msg_t          msg_q, msg_d;
  logic          ov_d;
  logic          commit_d, abort_d, drop_d;
  logic [IW-1:0] commit_slot_d, abort_slot_d;
  logic [AW-1:0] commit_partner_d;

  logic          accept_c, for_me_c, step1_c, step3_c;
  logic          hit_c, free_c, expired_c;
  logic [IW-1:0] hit_idx_c, free_idx_c, sel_idx_c;
  logic [AW-1:0] s3_idx_c;

  // Source and address of inbound messages are never needed by the responder.
  logic unused_fields;
  assign unused_fields = ^{in_src, in_address};

  assign in_ready = !out_valid;

  // Message classification plus retransmit-match and free-slot search on pre-edge state.
  always_comb begin
    accept_c   = in_valid && !out_valid;
    for_me_c   = accept_c && (in_dest == SELF_ID) && (in_key == SELF_ID);
    step1_c    = for_me_c && (in_type == T_NA);
    step3_c    = for_me_c && (in_type == T_N);
    s3_idx_c   = in_nonce1 - AW'(NONCE_BASE);
    hit_c      = 1'b0;
    hit_idx_c  = '0;
    free_c     = 1'b0;
    free_idx_c = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      if (!hit_c && st_q[k] == WAITING && partner_q[k] == in_nonce2 && na_q[k] == in_nonce1) begin
        hit_c     = 1'b1;
        hit_idx_c = IW'(k);
      end
      if (!free_c && st_q[k] == SLEEPING) begin
        free_c     = 1'b1;
        free_idx_c = IW'(k);
      end
    end
    sel_idx_c = hit_c ? hit_idx_c : free_idx_c;
  end

  // Next-state for slots, event pulses and the outbound buffer.
  always_comb begin
    st_d             = st_q;
    partner_d        = partner_q;
    na_d             = na_q;
    cnt_d            = cnt_q;
    msg_d            = msg_q;
    ov_d             = out_valid && !out_ready;
    commit_d         = 1'b0;
    commit_slot_d    = commit_slot;
    commit_partner_d = commit_partner;
    abort_d          = 1'b0;
    abort_slot_d     = abort_slot;
    drop_d           = step1_c && !hit_c && !free_c;
    expired_c        = 1'b0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      if (st_q[k] == WAITING) begin
        if (step3_c && s3_idx_c == AW'(k)) begin
          st_d[k]          = COMMITTED;
          commit_d         = 1'b1;
          commit_slot_d    = IW'(k);
          commit_partner_d = partner_q[k];
        end else if (step1_c && hit_c && hit_idx_c == IW'(k)) begin
          cnt_d[k] = CW'(TIMEOUT);
        end else if (cnt_q[k] > CW'(1)) begin
          cnt_d[k] = cnt_q[k] - CW'(1);
        end else if (!expired_c) begin
          // lowest expiring slot goes first; the rest hold at 1
          expired_c    = 1'b1;
          st_d[k]      = SLEEPING;
          cnt_d[k]     = '0;
          abort_d      = 1'b1;
          abort_slot_d = IW'(k);
        end
      end
      if (st_q[k] == COMMITTED && release_valid && release_slot == IW'(k))
        st_d[k] = SLEEPING;
      if (step1_c && !hit_c && free_c && free_idx_c == IW'(k)) begin
        st_d[k]      = WAITING;
        partner_d[k] = in_nonce2;
        na_d[k]      = in_nonce1;
        cnt_d[k]     = CW'(TIMEOUT);
      end
    end
    if (step1_c && (hit_c || free_c)) begin
      ov_d          = 1'b1;
      msg_d.mtype   = T_NNA;
      msg_d.src     = SELF_ID;
      msg_d.dest    = in_nonce2;
      msg_d.key     = in_nonce2;
      msg_d.nonce1  = in_nonce1;
      msg_d.nonce2  = AW'(NONCE_BASE) + AW'(sel_idx_c);
      msg_d.address = SELF_ID;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
        st_q[k]      <= SLEEPING;
        partner_q[k] <= '0;
        na_q[k]      <= '0;
        cnt_q[k]     <= '0;
      end
      msg_q          <= '0;
      out_valid      <= 1'b0;
      commit         <= 1'b0;
      commit_slot    <= '0;
      commit_partner <= '0;
      abort          <= 1'b0;
      abort_slot     <= '0;
      drop           <= 1'b0;
    end else begin
      st_q           <= st_d;
      partner_q      <= partner_d;
      na_q           <= na_d;
      cnt_q          <= cnt_d;
      msg_q          <= msg_d;
      out_valid      <= ov_d;
      commit         <= commit_d;
      commit_slot    <= commit_slot_d;
      commit_partner <= commit_partner_d;
      abort          <= abort_d;
      abort_slot     <= abort_slot_d;
      drop           <= drop_d;
    end
  end

  assign out_type    = msg_q.mtype;
  assign out_src     = msg_q.src;
  assign out_dest    = msg_q.dest;
  assign out_key     = msg_q.key;
  assign out_nonce1  = msg_q.nonce1;
  assign out_nonce2  = msg_q.nonce2;
  assign out_address = msg_q.address;

  always_comb begin
    slot_state = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++)
      slot_state[2*k +: 2] = st_q[k];
  end

endmodule
